// File: rtl/board_move_writer_if.sv
// -----------------------------------------------------------------------------
// board_move_writer_if
//
// Groups the move-command handshake and the single-port memory channel used by
// board_move_writer. Clock and reset are not part of the interface.
//
// Handshake: a command transfers on a rising clock edge where iMOVE_VALID and
// oMOVE_READY are both high. iSRC/iDST are sampled only on that edge. oMOVE_READY
// depends only on the writer's state, never on iMOVE_VALID. Once the writer
// accepts a command, it ignores the command inputs until it signals oDONE.
//
// Signals:
//   iMOVE_VALID      command present (master -> writer)
//   iSRC, iDST       source / destination square 0..63
//   oMOVE_READY      writer can accept a command
//   oDONE            one-cycle pulse at the end of every accepted command
//   oERROR           with oDONE: command rejected, nothing written
//   oCAPTURE         with oDONE: destination piece was overwritten
//   oCAPTURED_PIECE  previous destination word of the last capture
//   oMOVE_COUNT      committed moves, modulo 2^16
//   oADDR/oWDATA/oWREN  memory request
//   iRDATA           memory read data, one cycle after the address
//
// Modports: slave = the writer, master = the command source / memory side.
// -----------------------------------------------------------------------------
interface board_move_writer_if;
    logic        iMOVE_VALID;
    logic [5:0]  iSRC;
    logic [5:0]  iDST;
    logic        oMOVE_READY;
    logic        oDONE;
    logic        oERROR;
    logic        oCAPTURE;
    logic [31:0] oCAPTURED_PIECE;
    logic [15:0] oMOVE_COUNT;
    logic [11:0] oADDR;
    logic [31:0] oWDATA;
    logic        oWREN;
    logic [31:0] iRDATA;

    modport slave (
        input  iMOVE_VALID, iSRC, iDST, iRDATA,
        output oMOVE_READY, oDONE, oERROR, oCAPTURE, oCAPTURED_PIECE,
               oMOVE_COUNT, oADDR, oWDATA, oWREN
    );

    modport master (
        output iMOVE_VALID, iSRC, iDST, iRDATA,
        input  oMOVE_READY, oDONE, oERROR, oCAPTURE, oCAPTURED_PIECE,
               oMOVE_COUNT, oADDR, oWDATA, oWREN
    );
endinterface

// File: rtl/board_move_writer.sv
// -----------------------------------------------------------------------------
// board_move_writer
//
// Moves a chess piece in the board image held in data memory. A move command
// (source, destination square) is accepted over a valid/ready handshake. The
// block then performs a fixed-latency read-modify-write: it reads both squares,
// checks the move, writes the source piece to the destination and clears the
// source. It reports done / error / capture and counts committed moves.
//
// Ports:
//   iCLK        master clock, rising edge
//   iRST_n      asynchronous active-low reset
//   bus         board_move_writer_if.slave (command handshake + memory channel)
//   oDBG_STATE  current FSM state encoding, for observation only
//
// The memory has a registered address and an unregistered q. The word addressed
// in cycle N therefore appears on iRDATA in cycle N+1. The memory outputs are
// decoded directly from the state register for this reason: the read of each
// square is issued in the state before the one that consumes it.
// -----------------------------------------------------------------------------
module board_move_writer #(
    parameter logic [11:0] BOARD_BASE = 12'd0,
    parameter logic [31:0] EMPTY_CODE = 32'd0
) (
    input  logic                       iCLK,
    input  logic                       iRST_n,
    board_move_writer_if.slave         bus,
    output logic [2:0]                 oDBG_STATE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_SRC = 3'd1,
        RD_DST = 3'd2,
        CHECK  = 3'd3,
        WR_DST = 3'd4,
        WR_SRC = 3'd5,
        FIN    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  src_q, src_d;
    logic [5:0]  dst_q, dst_d;
    logic [31:0] src_piece_q, src_piece_d;
    logic [31:0] dst_piece_q, dst_piece_d;
    logic        err_q, err_d;
    logic        cap_q, cap_d;
    logic [31:0] captured_q, captured_d;
    logic [15:0] count_q, count_d;

    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic        ready;
    logic        done;
    logic        error;
    logic        capture;

    logic [11:0] src_addr;
    logic [11:0] dst_addr;

    // 12-bit wrap-around arithmetic; BOARD_BASE must leave room for 64 squares.
    assign src_addr = BOARD_BASE + {6'd0, src_q};
    assign dst_addr = BOARD_BASE + {6'd0, dst_q};

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= IDLE;
            src_q       <= 6'd0;
            dst_q       <= 6'd0;
            src_piece_q <= 32'd0;
            dst_piece_q <= 32'd0;
            err_q       <= 1'b0;
            cap_q       <= 1'b0;
            captured_q  <= 32'd0;
            count_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            src_piece_q <= src_piece_d;
            dst_piece_q <= dst_piece_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            captured_q  <= captured_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        src_piece_d = src_piece_q;
        dst_piece_d = dst_piece_q;
        err_d       = err_q;
        cap_d       = cap_q;
        captured_d  = captured_q;
        count_d     = count_q;

        addr    = BOARD_BASE;
        wdata   = EMPTY_CODE;
        wren    = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        error   = 1'b0;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.iMOVE_VALID) begin
                    src_d   = bus.iSRC;
                    dst_d   = bus.iDST;
                    state_d = RD_SRC;
                end
            end
            RD_SRC: begin
                addr    = src_addr;
                state_d = RD_DST;
            end
            RD_DST: begin
                // iRDATA carries the source word requested in RD_SRC.
                addr        = dst_addr;
                src_piece_d = bus.iRDATA;
                state_d     = CHECK;
            end
            CHECK: begin
                // iRDATA carries the destination word requested in RD_DST.
                dst_piece_d = bus.iRDATA;
                if ((src_piece_q == EMPTY_CODE) || (src_q == dst_q)) begin
                    err_d   = 1'b1;
                    cap_d   = 1'b0;
                    state_d = FIN;
                end else begin
                    err_d   = 1'b0;
                    cap_d   = (bus.iRDATA != EMPTY_CODE);
                    state_d = WR_DST;
                end
            end
            WR_DST: begin
                // Destination is written first so an interrupted move never
                // loses the piece; at worst it is duplicated.
                addr    = dst_addr;
                wdata   = src_piece_q;
                wren    = 1'b1;
                state_d = WR_SRC;
            end
            WR_SRC: begin
                addr    = src_addr;
                wdata   = EMPTY_CODE;
                wren    = 1'b1;
                count_d = count_q + 16'd1;
                if (cap_q) begin
                    captured_d = dst_piece_q;
                end
                state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                error   = err_q;
                capture = cap_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.oMOVE_READY     = ready;
    assign bus.oDONE           = done;
    assign bus.oERROR          = error;
    assign bus.oCAPTURE        = capture;
    assign bus.oCAPTURED_PIECE = captured_q;
    assign bus.oMOVE_COUNT     = count_q;
    assign bus.oADDR           = addr;
    assign bus.oWDATA          = wdata;
    assign bus.oWREN           = wren;
    assign oDBG_STATE          = state_q;

endmodule

// File: tb/tb_board_move_writer.sv
// -----------------------------------------------------------------------------
// tb_board_move_writer
//
// Directed bench for board_move_writer with BOARD_BASE = 256. The memory model
// has a registered address and combinational read data. Inputs are driven on the
// falling edge, and outputs are sampled on the falling edge. Edge 0 is the
// accepting rising edge, and "cycle k" is the clock period that follows rising
// edge k.
// -----------------------------------------------------------------------------
module tb_board_move_writer;

    localparam logic [11:0] BASE = 12'd256;

    logic        iCLK;
    logic        iRST_n;
    logic [2:0]  dbg_state;

    board_move_writer_if bus();

    board_move_writer #(
        .BOARD_BASE (BASE),
        .EMPTY_CODE (32'd0)
    ) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .bus        (bus),
        .oDBG_STATE (dbg_state)
    );

    // ---------------- clock ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:4095];
    logic [11:0] raddr_q;
    logic        tb_we;
    logic [11:0] tb_waddr;
    logic [31:0] tb_wdata;

    always @(posedge iCLK) begin
        if (bus.oWREN) mem[bus.oADDR] <= bus.oWDATA;
        if (tb_we)     mem[tb_waddr]  <= tb_wdata;
        raddr_q <= bus.oADDR;
    end
    assign bus.iRDATA = mem[raddr_q];

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(negedge iCLK);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(posedge iCLK);
        #1 tb_we = 1'b0;
    endtask

    // Issues one command and observes it until oDONE (bounded to 12 cycles).
    // done_k = 0 means oDONE never arrived.
    task automatic run_cmd(input logic [5:0] s, input logic [5:0] d,
                           output int done_k, output logic err, output logic cap,
                           output int wr_n, output logic [11:0] a0,
                           output logic [11:0] a1, output logic [31:0] d0,
                           output logic [15:0] cnt);
        done_k = 0; err = 1'b0; cap = 1'b0; wr_n = 0;
        a0 = '0; a1 = '0; d0 = '0; cnt = '0;
        @(negedge iCLK);
        bus.iMOVE_VALID = 1'b1;
        bus.iSRC = s;
        bus.iDST = d;
        @(posedge iCLK);
        for (int k = 1; k <= 12; k++) begin
            @(negedge iCLK);
            if (k == 1) begin
                // Later changes to the command inputs must not affect this move.
                bus.iMOVE_VALID = 1'b0;
                bus.iSRC = ~s;
                bus.iDST = ~d;
            end
            if (bus.oWREN) begin
                if (wr_n == 0) begin
                    a0 = bus.oADDR;
                    d0 = bus.oWDATA;
                end else if (wr_n == 1) begin
                    a1 = bus.oADDR;
                end
                wr_n++;
            end
            if (bus.oDONE) begin
                done_k = k;
                err    = bus.oERROR;
                cap    = bus.oCAPTURE;
                cnt    = bus.oMOVE_COUNT;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST_n = 1'b0;
        @(negedge iCLK);
        iRST_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int saw_done;
        @(negedge iCLK);
        n_tests++; if (bus.oMOVE_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.oMOVE_READY); end
        n_tests++; if (bus.oWREN !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", bus.oWREN); end
        n_tests++; if (bus.oADDR !== BASE) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", bus.oADDR, BASE); end
        n_tests++; if (bus.oMOVE_COUNT !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", bus.oMOVE_COUNT); end
        n_tests++; if (bus.oDONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.oDONE); end
        n_tests++; if (bus.oCAPTURED_PIECE !== 32'd0) begin n_fail++; $display("FAIL reset_captured: got %h expected 0", bus.oCAPTURED_PIECE); end
        iRST_n = 1'b1;

        // Reset during RD_DST of a legal move 40 -> 41.
        poke(BASE + 12'd40, 32'h55);
        poke(BASE + 12'd41, 32'h0);
        @(negedge iCLK);
        bus.iMOVE_VALID = 1'b1;
        bus.iSRC = 6'd40;
        bus.iDST = 6'd41;
        @(posedge iCLK);
        @(negedge iCLK);
        bus.iMOVE_VALID = 1'b0;
        @(negedge iCLK);            // cycle 2: RD_DST
        n_tests++; if (bus.oADDR !== BASE + 12'd41) begin n_fail++; $display("FAIL mid_rd_dst_addr: got %h expected %h", bus.oADDR, BASE + 12'd41); end
        iRST_n = 1'b0;
        #1;
        n_tests++; if (bus.oMOVE_READY !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", bus.oMOVE_READY); end
        n_tests++; if (bus.oWREN !== 1'b0) begin n_fail++; $display("FAIL mid_reset_wren: got %b expected 0", bus.oWREN); end
        @(negedge iCLK);
        iRST_n = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge iCLK);
            if (bus.oDONE || bus.oWREN) saw_done = 1;
        end
        n_tests++; if (saw_done !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d expected 0", saw_done); end
        n_tests++; if (mem[BASE + 12'd41] !== 32'h0) begin n_fail++; $display("FAIL mid_reset_mem: got %h expected 0", mem[BASE + 12'd41]); end
    endtask

    task automatic test_quiet_move();
        int dk, wn; logic e, c; logic [11:0] a0, a1; logic [31:0] d0; logic [15:0] cnt;
        poke(BASE + 12'd12, 32'h11);
        poke(BASE + 12'd28, 32'h0);
        run_cmd(6'd12, 6'd28, dk, e, c, wn, a0, a1, d0, cnt);
        n_tests++; if (dk !== 6) begin n_fail++; $display("FAIL quiet_done_cycle: got %0d expected 6", dk); end
        n_tests++; if (e !== 1'b0 || c !== 1'b0) begin n_fail++; $display("FAIL quiet_flags: got err=%b cap=%b expected 0 0", e, c); end
        n_tests++; if (wn !== 2) begin n_fail++; $display("FAIL quiet_wr_count: got %0d expected 2", wn); end
        n_tests++; if (a0 !== BASE + 12'd28 || a1 !== BASE + 12'd12 || d0 !== 32'h11) begin n_fail++; $display("FAIL quiet_wr_order: got a0=%h a1=%h d0=%h expected %h %h 11", a0, a1, d0, BASE + 12'd28, BASE + 12'd12); end
        n_tests++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL quiet_count: got %h expected 1", cnt); end
        n_tests++; if (mem[BASE + 12'd28] !== 32'h11 || mem[BASE + 12'd12] !== 32'h0) begin n_fail++; $display("FAIL quiet_mem: got dst=%h src=%h expected 11 0", mem[BASE + 12'd28], mem[BASE + 12'd12]); end
    endtask

    task automatic test_capture();
        int dk, wn; logic e, c; logic [11:0] a0, a1; logic [31:0] d0; logic [15:0] cnt;
        poke(BASE + 12'd35, 32'h29);
        run_cmd(6'd28, 6'd35, dk, e, c, wn, a0, a1, d0, cnt);
        n_tests++; if (dk !== 6 || e !== 1'b0 || c !== 1'b1) begin n_fail++; $display("FAIL capture_flags: got k=%0d err=%b cap=%b expected 6 0 1", dk, e, c); end
        n_tests++; if (bus.oCAPTURED_PIECE !== 32'h29) begin n_fail++; $display("FAIL capture_piece: got %h expected 29", bus.oCAPTURED_PIECE); end
        n_tests++; if (mem[BASE + 12'd35] !== 32'h11 || mem[BASE + 12'd28] !== 32'h0) begin n_fail++; $display("FAIL capture_mem: got dst=%h src=%h expected 11 0", mem[BASE + 12'd35], mem[BASE + 12'd28]); end
        n_tests++; if (cnt !== 16'd2) begin n_fail++; $display("FAIL capture_count: got %h expected 2", cnt); end
    endtask

    task automatic test_reject();
        int dk, wn; logic e, c; logic [11:0] a0, a1; logic [31:0] d0; logic [15:0] cnt;
        // Empty source square.
        poke(BASE + 12'd5, 32'h0);
        poke(BASE + 12'd6, 32'h77);
        run_cmd(6'd5, 6'd6, dk, e, c, wn, a0, a1, d0, cnt);
        n_tests++; if (dk !== 4 || e !== 1'b1 || c !== 1'b0) begin n_fail++; $display("FAIL reject_empty_flags: got k=%0d err=%b cap=%b expected 4 1 0", dk, e, c); end
        n_tests++; if (wn !== 0) begin n_fail++; $display("FAIL reject_empty_writes: got %0d expected 0", wn); end
        n_tests++; if (mem[BASE + 12'd6] !== 32'h77 || cnt !== 16'd2) begin n_fail++; $display("FAIL reject_empty_state: got mem=%h cnt=%h expected 77 2", mem[BASE + 12'd6], cnt); end
        // Source equals destination.
        poke(BASE + 12'd9, 32'h33);
        run_cmd(6'd9, 6'd9, dk, e, c, wn, a0, a1, d0, cnt);
        n_tests++; if (dk !== 4 || e !== 1'b1 || c !== 1'b0) begin n_fail++; $display("FAIL reject_same_flags: got k=%0d err=%b cap=%b expected 4 1 0", dk, e, c); end
        n_tests++; if (wn !== 0) begin n_fail++; $display("FAIL reject_same_writes: got %0d expected 0", wn); end
        n_tests++; if (mem[BASE + 12'd9] !== 32'h33 || cnt !== 16'd2) begin n_fail++; $display("FAIL reject_same_state: got mem=%h cnt=%h expected 33 2", mem[BASE + 12'd9], cnt); end
        n_tests++; if (bus.oCAPTURED_PIECE !== 32'h29) begin n_fail++; $display("FAIL reject_captured_kept: got %h expected 29", bus.oCAPTURED_PIECE); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] cs [3];
        logic [5:0] cd [3];
        int acc [3];
        int n, seen_319, got_done;
        cs[0] = 6'd0;  cd[0] = 6'd63;
        cs[1] = 6'd63; cd[1] = 6'd1;
        cs[2] = 6'd1;  cd[2] = 6'd2;
        do_reset();
        poke(BASE + 12'd0, 32'hA1);
        poke(BASE + 12'd63, 32'h0);
        poke(BASE + 12'd1, 32'h0);
        poke(BASE + 12'd2, 32'h0);
        n = 0; seen_319 = 0; got_done = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        @(negedge iCLK);
        bus.iMOVE_VALID = 1'b1;
        bus.iSRC = cs[0];
        bus.iDST = cd[0];
        for (int c = 0; c < 40 && n < 3; c++) begin
            if (bus.oWREN && bus.oADDR == 12'd319 && bus.oWDATA == 32'hA1) seen_319 = 1;
            if (bus.oMOVE_READY) begin
                acc[n] = c;
                n++;
            end
            @(posedge iCLK);
            @(negedge iCLK);
            if (n < 3) begin
                bus.iSRC = cs[n];
                bus.iDST = cd[n];
            end else begin
                bus.iMOVE_VALID = 1'b0;
            end
        end
        bus.iMOVE_VALID = 1'b0;
        for (int k = 0; k < 12 && got_done == 0; k++) begin
            if (bus.oDONE) got_done = 1;
            else @(negedge iCLK);
        end
        n_tests++; if (n !== 3 || got_done !== 1) begin n_fail++; $display("FAIL b2b_accepts: got n=%0d done=%0d expected 3 1", n, got_done); end
        n_tests++; if (acc[1] - acc[0] !== 7 || acc[2] - acc[1] !== 7) begin n_fail++; $display("FAIL b2b_spacing: got %0d %0d expected 7 7", acc[1] - acc[0], acc[2] - acc[1]); end
        n_tests++; if (seen_319 !== 1) begin n_fail++; $display("FAIL b2b_addr_319: got %0d expected 1", seen_319); end
        n_tests++; if (bus.oMOVE_COUNT !== 16'd3) begin n_fail++; $display("FAIL b2b_count: got %h expected 3", bus.oMOVE_COUNT); end
        n_tests++; if (mem[BASE + 12'd2] !== 32'hA1 || mem[BASE + 12'd0] !== 32'h0 || mem[12'd319] !== 32'h0 || mem[BASE + 12'd1] !== 32'h0) begin n_fail++; $display("FAIL b2b_mem: got sq2=%h sq0=%h sq63=%h sq1=%h expected A1 0 0 0", mem[BASE + 12'd2], mem[BASE + 12'd0], mem[12'd319], mem[BASE + 12'd1]); end
    endtask

    task automatic test_wrap();
        int dk, wn; logic e, c; logic [11:0] a0, a1; logic [31:0] d0; logic [15:0] cnt;
        @(negedge iCLK);
        force dut.count_q = 16'hFFFF;
        @(posedge iCLK);
        @(negedge iCLK);
        release dut.count_q;
        @(negedge iCLK);
        n_tests++; if (bus.oMOVE_COUNT !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", bus.oMOVE_COUNT); end
        poke(BASE + 12'd3, 32'h0);
        run_cmd(6'd2, 6'd3, dk, e, c, wn, a0, a1, d0, cnt);
        n_tests++; if (dk !== 6 || cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got k=%0d cnt=%h expected 6 0000", dk, cnt); end
        n_tests++; if (mem[BASE + 12'd3] !== 32'hA1) begin n_fail++; $display("FAIL wrap_mem: got %h expected a1", mem[BASE + 12'd3]); end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        iRST_n          = 1'b0;
        tb_we           = 1'b0;
        tb_waddr        = '0;
        tb_wdata        = '0;
        bus.iMOVE_VALID = 1'b0;
        bus.iSRC        = '0;
        bus.iDST        = '0;
        repeat (2) @(posedge iCLK);
        test_reset();
        test_quiet_move();
        test_capture();
        test_reject();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_move_writer.md
# board_move_writer

Hardware-side writer for the chess board image in data memory. It is the counterpart of the VGA board reader, which only reads squares. It accepts a move command (source square, destination square) over a valid/ready handshake. It then performs a fixed-latency read-modify-write on a synchronous single-port memory channel: it moves the source piece to the destination and clears the source. It reports completion, capture and rejection, and keeps a count of committed moves.

## Interface
Parameters:
- BOARD_BASE, 12'd0, word address of square 0; square n lives at BOARD_BASE + n.
- EMPTY_CODE, 32'd0, word value meaning "no piece".

Ports (one clock; reset is asynchronous and active-low):
- iCLK  input  1  master clock; every register updates on its rising edge.
- iRST_n  input  1  asynchronous active-low reset.
- iMOVE_VALID  input  1  move command present.
- iSRC  input  6  source square 0..63.
- iDST  input  6  destination square 0..63.
- oMOVE_READY  output  1  block can accept a command.
- oDONE  output  1  one-cycle pulse at the end of every accepted command.
- oERROR  output  1  valid with oDONE: the command was rejected and no writes were made.
- oCAPTURE  output  1  valid with oDONE: the destination held a piece that was overwritten.
- oCAPTURED_PIECE  output  32  previous destination word; updated only on a capture.
- oMOVE_COUNT  output  16  number of committed moves; wraps modulo 2^16.
- oADDR  output  12  memory address.
- oWDATA  output  32  memory write data.
- oWREN  output  1  memory write enable.
- iRDATA  input  32  memory read data; valid one cycle after the address is presented (registered address, unregistered q).

## Operation
- States: IDLE, RD_SRC, RD_DST, CHECK, WR_DST, WR_SRC, FIN.
- IDLE:
  - oMOVE_READY = 1.
  - When iMOVE_VALID && oMOVE_READY, latch iSRC/iDST into src_r/dst_r and go to RD_SRC.
- RD_SRC: oADDR = BOARD_BASE + src_r. Go to RD_DST.
- RD_DST: oADDR = BOARD_BASE + dst_r. Latch iRDATA into src_piece. Go to CHECK.
- CHECK:
  - Latch iRDATA into dst_piece.
  - Reject if src_piece == EMPTY_CODE or src_r == dst_r. On reject, set err_r = 1, set cap_r = 0, and go to FIN.
  - Otherwise set err_r = 0 and cap_r = (iRDATA != EMPTY_CODE). Go to WR_DST.
- WR_DST: oADDR = BOARD_BASE + dst_r, oWDATA = src_piece, oWREN = 1. Go to WR_SRC.
- WR_SRC:
  - oADDR = BOARD_BASE + src_r, oWDATA = EMPTY_CODE, oWREN = 1.
  - On exit, increment oMOVE_COUNT.
  - If cap_r, load oCAPTURED_PIECE with dst_piece.
  - Go to FIN.
- FIN: oDONE = 1, oERROR = err_r, oCAPTURE = cap_r. Go to IDLE.
- Memory outputs in any state not listed above: oADDR = BOARD_BASE, oWDATA = EMPTY_CODE, oWREN = 0.
- oDONE, oERROR, oCAPTURE and oMOVE_READY are decoded only from the state register and flag registers, never from inputs.
- Address arithmetic is 12-bit: BOARD_BASE + {6'd0, sq}, truncated. The block does not check for overflow past 4095; BOARD_BASE ≤ 4032 is required.
- iSRC/iDST are sampled only at the accepting edge. Changes after that edge have no effect on the command in flight.

## Timing
- Reset values: state = IDLE, oMOVE_READY = 1, oDONE = oERROR = oCAPTURE = 0, oCAPTURED_PIECE = 0, oMOVE_COUNT = 0, oADDR = BOARD_BASE, oWDATA = 0, oWREN = 0, err_r = cap_r = 0.
- Let edge 0 be the accepting edge. Legal-move schedule, by cycle after edge 0:
  - Cycle 1: RD_SRC.
  - Cycle 2: RD_DST.
  - Cycle 3: CHECK.
  - Cycle 4: WR_DST.
  - Cycle 5: WR_SRC.
  - Cycle 6: FIN (oDONE high).
  - Cycle 7: IDLE; ready again. The next command can be accepted at the end of cycle 7.
- Rejected command: CHECK in cycle 3, FIN in cycle 4, IDLE in cycle 5. oWREN never asserts.
- Throughput: at most one command per 7 cycles (legal) or 5 cycles (rejected).
- Exactly two write cycles per committed move: destination first, then source.
- oMOVE_COUNT is visible incremented in the FIN cycle. 0xFFFF + 1 = 0x0000.
- iMOVE_VALID held high continuously: a new command is accepted in every IDLE cycle. This yields back-to-back commands with no extra gap.
- Asynchronous reset mid-command:
  - oWREN drops immediately and the state returns to IDLE.
  - No oDONE is produced.
  - A reset between WR_DST and WR_SRC leaves the piece duplicated in memory. This is accepted; software reinitialises the board after reset.

## Test plan
- Reset, then idle: oMOVE_READY = 1, oWREN = 0, oADDR = BOARD_BASE, oMOVE_COUNT = 0. Asserting iRST_n low mid-RD_DST returns to IDLE with no oDONE.
- Quiet move: mem[12] = 32'h11, mem[28] = 0, command src = 12, dst = 28.
  - oDONE in cycle 6, oERROR = 0, oCAPTURE = 0.
  - Afterwards mem[28] = 32'h11, mem[12] = 0, oMOVE_COUNT = 1.
- Capture: mem[28] = 32'h11, mem[35] = 32'h29, command src = 28, dst = 35.
  - oCAPTURE = 1, oCAPTURED_PIECE = 32'h29.
  - Afterwards mem[35] = 32'h11, mem[28] = 0.
- Rejects, each giving oDONE in cycle 4 with oERROR = 1 and zero oWREN cycles, memory unchanged, count unchanged:
  - src = 5 when mem[5] = 0.
  - src = dst = 9.
- Back-to-back: iMOVE_VALID held high across three legal commands gives accepts exactly 7 cycles apart and oMOVE_COUNT 0 → 3. With BOARD_BASE = 12'd256, square 63 is addressed as 12'd319.
- Wrap: preload oMOVE_COUNT = 16'hFFFF via 65535 moves (or a force), then one legal move gives 16'h0000.
